// File: rtl/divider_pkg.sv
// Shared constants and FSM state encoding for the signed restoring divider.
package divider_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [DEF_WIDTH-1:0] MOST_NEG   = {1'b1, {(DEF_WIDTH-1){1'b0}}};
    localparam logic [DEF_WIDTH-1:0] Q_ALL_ONES = '1;

endpackage

// File: rtl/signed_divider_16bit_if.sv
// Request/result bundle for the signed divider: master drives operands, slave returns the result.
interface signed_divider_16bit_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                    en;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH-1:0] Quot;
    logic signed [WIDTH-1:0] Rem;
    logic                    done;
    logic                    div_by_zero;
    logic                    ovf;

    modport master (output en, A, B, input Quot, Rem, done, div_by_zero, ovf);
    modport slave  (input en, A, B, output Quot, Rem, done, div_by_zero, ovf);
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; doubles as abs() when neg is the operand's sign bit.
module div_sign_fix #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);
    // -MOST_NEG wraps to the same bit pattern, read as the unsigned magnitude 2^(WIDTH-1)
    assign res = neg ? ((~val) + 1'b1) : val;
endmodule

// File: rtl/signed_divider_16bit.sv
// Multi-cycle signed divider: unsigned restoring core on magnitudes, sign fix-up, truncation toward zero.
module signed_divider_16bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH-1:0] Quot,
    output logic signed [WIDTH-1:0] Rem,
    output logic                    done,
    output logic                    div_by_zero,
    output logic                    ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg, d_reg, r_reg;
    logic             neg_q, neg_r, ovf_pend;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(A),     .neg(A[WIDTH-1]), .res(a_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(B),     .neg(B[WIDTH-1]), .res(b_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.val(q_reg), .neg(neg_q),      .res(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.val(r_reg), .neg(neg_r),      .res(r_fix));

    // WIDTH+1-bit trial remainder; when it fits the difference is below the divisor, so WIDTH bits hold it
    assign shifted = {r_reg, q_reg[WIDTH-1]};
    assign fits    = shifted >= {1'b0, d_reg};
    assign diff    = shifted[WIDTH-1:0] - d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            Quot        <= '0;
            Rem         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    q_reg       <= a_mag;
                    d_reg       <= b_mag;
                    r_reg       <= '0;
                    cnt         <= '0;
                    neg_q       <= A[WIDTH-1] ^ B[WIDTH-1];
                    neg_r       <= A[WIDTH-1];
                    ovf_pend    <= (A == MIN_VAL) && (B == ONES);
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    ovf         <= 1'b0;
                    if (B == '0) begin
                        Quot        <= ONES;
                        Rem         <= A;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (!en) begin
                    state <= IDLE;
                end else begin
                    q_reg <= {q_reg[WIDTH-2:0], fits};
                    r_reg <= fits ? diff : shifted[WIDTH-1:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: if (!en) begin
                    state <= IDLE;
                end else begin
                    Quot  <= q_fix;
                    Rem   <= r_fix;
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: if (!en) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_divider_16bit.sv
// Scoreboard bench for signed_divider_16bit: reference results from integer / and %, latency and abort/reset checks.
module tb_signed_divider_16bit;
    import divider_pkg::*;
    localparam int W = DEF_WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    signed_divider_16bit_if #(.WIDTH(W)) dif ();

    signed_divider_16bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (dif.en),
        .A           (dif.A),
        .B           (dif.B),
        .Quot        (dif.Quot),
        .Rem         (dif.Rem),
        .done        (dif.done),
        .div_by_zero (dif.div_by_zero),
        .ovf         (dif.ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        logic                dbz;
        logic                ovf;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    logic signed [W-1:0] last_q, last_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = W'(a); e.dbz = 1'b1; e.ovf = 1'b0;
        end else begin
            e.q   = W'(a / b);
            e.r   = W'(a % b);
            e.dbz = 1'b0;
            e.ovf = (a == -(2**(W-1))) && (b == -1);
        end
        return e;
    endfunction

    task automatic run_op(input int a, input int b);
        exp_t e;
        int   edges;
        int   lat;
        lat = (b == 0) ? 1 : W + 2;
        sb.push_back(model(a, b));
        @(negedge clk);
        dif.A  = W'(a);
        dif.B  = W'(b);
        dif.en = 1'b1;
        edges  = 0;
        while (edges < 3 * W) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            // operands must be ignored once captured
            dif.A = ~dif.A;
            dif.B = dif.B + 16'sd3;
            if (dif.done) break;
        end
        chk("latency", 32'(edges), 32'(lat));
        e = sb.pop_front();
        chk("quot", 32'(dif.Quot), 32'(e.q));
        chk("rem",  32'(dif.Rem),  32'(e.r));
        chk("dbz",  32'(dif.div_by_zero), 32'(e.dbz));
        chk("ovf",  32'(dif.ovf), 32'(e.ovf));
        @(posedge clk); @(negedge clk);
        chk("hold_done", 32'(dif.done), 32'd1);
        chk("hold_quot", 32'(dif.Quot), 32'(e.q));
        dif.en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("done_clr", 32'(dif.done), 32'd0);
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        logic seen;
        dif.en = 1'b0;
        dif.A  = '0;
        dif.B  = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("rst_quot", 32'(dif.Quot), 32'd0);
        chk("rst_rem",  32'(dif.Rem),  32'd0);
        chk("rst_done", 32'(dif.done), 32'd0);
        chk("rst_dbz",  32'(dif.div_by_zero), 32'd0);
        chk("rst_ovf",  32'(dif.ovf), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(60, 7);
        run_op(-15, 4);
        run_op(15, -4);
        run_op(-100, -10);
        run_op(-9, 11);
        run_op(5, 0);
        run_op(-32768, -1);
        run_op(-32768, 1);

        // abort: en dropped before the 8th edge
        @(negedge clk);
        dif.A = 16'sd1000; dif.B = 16'sd3; dif.en = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk) dif.en = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); @(negedge clk);
            if (dif.done) seen = 1'b1;
        end
        chk("abort_done", 32'(seen), 32'd0);
        chk("abort_quot", 32'(dif.Quot), 32'(last_q));
        chk("abort_rem",  32'(dif.Rem),  32'(last_r));

        // asynchronous reset mid-operation
        @(negedge clk) dif.en = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_quot", 32'(dif.Quot), 32'd0);
        chk("arst_rem",  32'(dif.Rem),  32'd0);
        chk("arst_done", 32'(dif.done), 32'd0);
        chk("arst_dbz",  32'(dif.div_by_zero), 32'd0);
        chk("arst_ovf",  32'(dif.ovf), 32'd0);
        dif.en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_op(1000, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
